// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Source of the video timing for the pixel pipeline (default 1024x768 @ 60 Hz
// XGA, 65 MHz pixel clock). Produces the raster position plus sync and
// blanking flags. Every output is registered, and the flags are computed
// from the *next* count values. As a result, each flag always describes the
// position presented in the same cycle.
//
// Ports
//   pclk             in   1   pixel clock, rising edge
//   rst              in   1   synchronous, active-high reset (priority over en)
//   en               in   1   count enable; low freezes every output
//   hcount_out       out  11  horizontal pixel index, 0..H_TOTAL-1
//   vcount_out       out  11  vertical line index, 0..V_TOTAL-1
//   hsync_out        out  1   horizontal sync, active-high
//   vsync_out        out  1   vertical sync, active-high
//   hblnk_out        out  1   high outside the visible columns
//   vblnk_out        out  1   high outside the visible lines
//   frame_start_out  out  1   only with VGA_TIMING_FRAME_PULSE_EN defined:
//                             high for the one enabled cycle in which (0,0)
//                             is presented after a frame wrap
//
// Optional feature macro: VGA_TIMING_FRAME_PULSE_EN
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE     = 1024,
    parameter int H_SYNC_START = 1048,
    parameter int H_SYNC_W     = 136,
    parameter int H_TOTAL      = 1344,
    parameter int V_ACTIVE     = 768,
    parameter int V_SYNC_START = 771,
    parameter int V_SYNC_W     = 6,
    parameter int V_TOTAL      = 806
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out
`ifdef VGA_TIMING_FRAME_PULSE_EN
    ,
    output logic        frame_start_out
`endif
);

    // An inconsistent timing set stops elaboration.
    if (H_ACTIVE > H_SYNC_START || H_SYNC_START + H_SYNC_W > H_TOTAL || H_TOTAL > 2048) begin : g_bad_h
        $fatal(1, "vga_timing_gen: illegal horizontal timing parameters");
    end
    if (V_ACTIVE > V_SYNC_START || V_SYNC_START + V_SYNC_W > V_TOTAL || V_TOTAL > 2048) begin : g_bad_v
        $fatal(1, "vga_timing_gen: illegal vertical timing parameters");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;

    logic        w_h_last;
    logic        w_v_last;
    logic [10:0] w_hcount_nxt;
    logic [10:0] w_vcount_nxt;
    logic        w_hsync_nxt;
    logic        w_vsync_nxt;
    logic        w_hblnk_nxt;
    logic        w_vblnk_nxt;

    assign w_h_last = (r_hcount == H_LAST);
    assign w_v_last = (r_vcount == V_LAST);

    // Next raster position. With en low the position is held, so the flags
    // below recompute to the values already on the outputs.
    always_comb begin
        // NOTE: defaults first, so every path assigns and no latch is inferred.
        w_hcount_nxt = r_hcount;
        w_vcount_nxt = r_vcount;
        if (en) begin
            if (w_h_last) begin
                w_hcount_nxt = '0;
                w_vcount_nxt = w_v_last ? 11'd0 : r_vcount + 11'd1;
            end else begin
                w_hcount_nxt = r_hcount + 11'd1;
            end
        end
    end

    // Flags are decoded from the next position, which gives zero skew
    // against the registered counts. The comparisons are done as int
    // because a sync end can reach 2048, which does not fit in 11 bits.
    assign w_hblnk_nxt = (int'(w_hcount_nxt) >= H_ACTIVE);
    assign w_hsync_nxt = (int'(w_hcount_nxt) >= H_SYNC_START) &&
                         (int'(w_hcount_nxt) <  H_SYNC_START + H_SYNC_W);
    assign w_vblnk_nxt = (int'(w_vcount_nxt) >= V_ACTIVE);
    assign w_vsync_nxt = (int'(w_vcount_nxt) >= V_SYNC_START) &&
                         (int'(w_vcount_nxt) <  V_SYNC_START + V_SYNC_W);

    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
        end else begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            r_hsync  <= w_hsync_nxt;
            r_vsync  <= w_vsync_nxt;
            r_hblnk  <= w_hblnk_nxt;
            r_vblnk  <= w_vblnk_nxt;
        end
    end

    assign hcount_out = r_hcount;
    assign vcount_out = r_vcount;
    assign hsync_out  = r_hsync;
    assign vsync_out  = r_vsync;
    assign hblnk_out  = r_hblnk;
    assign vblnk_out  = r_vblnk;

`ifdef VGA_TIMING_FRAME_PULSE_EN
    // The pulse marks the (0,0) reached by a frame wrap. The (0,0) left by
    // reset is presented with the reset value 0. With en low, the pulse is
    // held together with the frozen position.
    logic r_frame_start;
    logic w_frame_start_nxt;

    assign w_frame_start_nxt = en ? (w_h_last && w_v_last) : r_frame_start;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign frame_start_out = r_frame_start;
`endif

endmodule
